bfloat16_lut_loader: RTL and testbench

Write-side sequencer for the 32-entry bfloat16 activation lookup table. Accepts a stream of bfloat16 table words over a valid/ready handshake after a start pulse. Replays each word as one `in_load_*` write cycle into the table-owning activation unit, at addresses 0..DEPTH-1 in order. Signals completion so the activation path can be used only after a full, consistent table is loaded.

---
 rtl/bfloat16_pkg.sv | 16 +
 rtl/bfloat16_lut_checksum.sv | 28 ++
 rtl/bfloat16_lut_loader.sv | 128 ++++++++++++
 tb/tb_bfloat16_lut_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfloat16_pkg.sv
// Shared constants and loader state type for the bfloat16 activation lookup table.
// Used by the table, the range decoder and the table loader.
package bfloat16_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

endpackage

// File: rtl/bfloat16_lut_checksum.sv
// Running 16-bit modular sum of the table words streamed in during one load.
// Only instantiated by the loader when BFLOAT16_LUT_LOADER_CHECKSUM_EN is defined.
module bfloat16_lut_checksum
  import bfloat16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_x,
  input  logic              i_clear,
  input  logic              i_accum,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge clk) begin
    if (rst_x) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_accum) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/bfloat16_lut_loader.sv
// Write-side sequencer: replays a DEPTH-word stream into the activation LUT, pulses done.
// Optional checksum word and err flag when BFLOAT16_LUT_LOADER_CHECKSUM_EN is defined.
module bfloat16_lut_loader
  import bfloat16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_x,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] in_load_data,
  output logic [ADDR_W-1:0] in_load_addr,
  output logic              in_load_enable,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     r_state;
  loader_state_t     w_state_next;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;
  logic              r_enable;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic              w_load_accept;
  logic              w_start;
  logic              w_last;

  // s_ready is a pure state decode so the source may wait on it before raising s_valid
  assign s_ready       = (r_state == ST_LOAD) || (r_state == ST_CHECK);
  assign w_accept      = s_valid && s_ready;
  assign w_load_accept = w_accept && (r_state == ST_LOAD);
  assign w_start       = start && (r_state == ST_IDLE);
  assign w_last        = (r_count == LAST_ADDR);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_accept && w_last) begin
`ifdef BFLOAT16_LUT_LOADER_CHECKSUM_EN
          w_state_next = ST_CHECK;
`else
          w_state_next = ST_DONE;
`endif
        end
      end
      ST_CHECK: begin
        if (w_accept) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      r_state  <= ST_IDLE;
      r_count  <= '0;
      r_data   <= '0;
      r_addr   <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_enable <= w_load_accept;
      r_busy   <= (w_state_next != ST_IDLE);
      r_done   <= (w_state_next == ST_DONE);
      if (w_start) begin
        r_count <= '0;
      end else if (w_load_accept) begin
        r_data <= s_data;
        r_addr <= r_count;
        // hold at the last address rather than wrapping; the state leaves LOAD here
        if (!w_last) r_count <= r_count + 1'b1;
      end
    end
  end

  assign in_load_data   = r_data;
  assign in_load_addr   = r_addr;
  assign in_load_enable = r_enable;
  assign busy           = r_busy;
  assign done           = r_done;

`ifdef BFLOAT16_LUT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] w_sum;
  logic              r_err;

  bfloat16_lut_checksum u_checksum (
    .clk     (clk),
    .rst_x   (rst_x),
    .i_clear (w_start),
    .i_accum (w_load_accept),
    .i_data  (s_data),
    .o_sum   (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst_x) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_accept && (r_state == ST_CHECK)) begin
      r_err <= (s_data != w_sum);
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bfloat16_lut_loader.sv
// Self-checking bench for bfloat16_lut_loader: per-cycle compare against a word-count model
// plus literal timing/data expectations for each directed load.
module tb_bfloat16_lut_loader;
  import bfloat16_pkg::*;

`ifdef BFLOAT16_LUT_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif
  localparam int NWORDS = DEPTH + CK;

  logic              clk = 1'b0;
  logic              rst_x = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] in_load_data;
  logic [ADDR_W-1:0] in_load_addr;
  logic              in_load_enable;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  bfloat16_lut_loader dut (
    .clk            (clk),
    .rst_x          (rst_x),
    .start          (start),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .in_load_data   (in_load_data),
    .in_load_addr   (in_load_addr),
    .in_load_enable (in_load_enable),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit cmp_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: a load is "active" from start until the cycle after its last word is consumed.
  bit                m_active = 0;
  int                m_n = 0;
  logic [DATA_W-1:0] m_sum = '0;
  bit                e_en = 0, e_done = 0, e_busy = 0, e_ready = 0, e_err = 0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [DATA_W-1:0] e_data = '0;

  always @(posedge clk) begin
    cyc++;
    e_en   = 0;
    e_done = 0;
    if (rst_x) begin
      m_active = 0;
      m_n = 0;
      m_sum = '0;
      e_err = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1;
        m_n = 0;
        m_sum = '0;
        e_err = 0;
      end
    end else if (m_n == NWORDS) begin
      m_active = 0;
    end else if (s_valid) begin
      if (m_n < DEPTH) begin
        e_en   = 1;
        e_addr = m_n[ADDR_W-1:0];
        e_data = s_data;
        m_sum  = m_sum + s_data;
      end else begin
        e_err = (s_data != m_sum);
      end
      m_n++;
      if (m_n == NWORDS) e_done = 1;
    end
    e_busy  = m_active;
    e_ready = m_active && (m_n < NWORDS);
  end

  int wr_count = 0, done_count = 0, done_cyc = -1, first_wr_cyc = -1, last_wr_cyc = -1;
  logic [ADDR_W-1:0] first_addr, last_addr;
  logic [DATA_W-1:0] first_data, last_data;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("s_ready", 32'(s_ready), 32'(e_ready));
      chk("in_load_enable", 32'(in_load_enable), 32'(e_en));
      if (e_en) begin
        chk("in_load_addr", 32'(in_load_addr), 32'(e_addr));
        chk("in_load_data", 32'(in_load_data), 32'(e_data));
      end
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(e_err));
      if (in_load_enable) begin
        wr_count++;
        if (wr_count == 1) begin
          first_wr_cyc = cyc;
          first_addr = in_load_addr;
          first_data = in_load_data;
        end
        last_wr_cyc = cyc;
        last_addr = in_load_addr;
        last_data = in_load_data;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  logic [DATA_W-1:0] words [0:DEPTH];

  task automatic fill_words(input logic [DATA_W-1:0] base, input bit good_ck, input logic [DATA_W-1:0] ck_word);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = base + DATA_W'(i);
      s = s + words[i];
    end
    words[DEPTH] = good_ck ? s : ck_word;
  endtask

  task automatic run_load(input int gap_pct, input int mid_start_at, input bit start_in_done,
                          input int abort_at, output int t0);
    bit finished;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    wr_count = 0; done_count = 0; done_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1;
    finished = 0;
    for (int k = 0; k < 500 && !finished; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      s_valid = 1'b0;
      if (abort_at >= 0 && m_n == abort_at) begin
        rst_x = 1'b1;
        @(posedge clk); #1;
        chk("rst_enable", 32'(in_load_enable), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        rst_x = 1'b0;
        finished = 1;
      end else if (!m_active) begin
        finished = 1;
      end else begin
        if (m_n < NWORDS) begin
          s_valid = ($urandom_range(0, 99) >= 32'(gap_pct));
          s_data  = words[m_n];
        end
        if (mid_start_at >= 0 && m_n == mid_start_at) start = 1'b1;
        if (start_in_done && m_n == NWORDS) start = 1'b1;
      end
    end
    start = 1'b0;
    s_valid = 1'b0;
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL load_timeout cyc=%0d actual=running required=finished", cyc);
    end
  endtask

  task automatic chk_full_rate(input string tag, input int t0);
    chk({tag, "_wr_count"}, 32'(wr_count), 32'd32);
    chk({tag, "_first_cyc"}, 32'(first_wr_cyc), 32'(t0 + 2));
    chk({tag, "_first_addr"}, 32'(first_addr), 32'd0);
    chk({tag, "_last_cyc"}, 32'(last_wr_cyc), 32'(t0 + 33));
    chk({tag, "_last_addr"}, 32'(last_addr), 32'd31);
    chk({tag, "_done_count"}, 32'(done_count), 32'd1);
    chk({tag, "_done_cyc"}, 32'(done_cyc), 32'(t0 + 33 + CK));
  endtask

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1;
    chk("reset_ready", 32'(s_ready), 32'd0);
    chk("reset_data", 32'(in_load_data), 32'd0);
    chk("reset_addr", 32'(in_load_addr), 32'd0);
    chk("reset_enable", 32'(in_load_enable), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst_x = 1'b0;
    repeat (2) @(posedge clk);

    fill_words(16'h3F80, 1'b1, 16'h0000);
    run_load(0, -1, 1'b0, -1, t0);
    $display("load full_rate t0=%0d writes=%0d done_cyc=%0d", t0, wr_count, done_cyc);
    chk_full_rate("full", t0);
    chk("full_first_data", 32'(first_data), 32'h3F80);
    chk("full_last_data", 32'(last_data), 32'h3F9F);

    run_load(50, -1, 1'b0, -1, t0);
    $display("load gaps t0=%0d writes=%0d done_cyc=%0d", t0, wr_count, done_cyc);
    chk("gap_wr_count", 32'(wr_count), 32'd32);
    chk("gap_done_count", 32'(done_count), 32'd1);
    chk("gap_done_after_last", 32'(done_cyc >= last_wr_cyc), 32'd1);
    chk("gap_last_data", 32'(last_data), 32'h3F9F);

    run_load(0, 10, 1'b1, -1, t0);
    $display("load ignored_starts t0=%0d writes=%0d done_cyc=%0d", t0, wr_count, done_cyc);
    chk_full_rate("istart", t0);
    repeat (2) @(posedge clk); #1;
    chk("istart_idle_after", 32'(busy), 32'd0);

    run_load(0, -1, 1'b0, 16, t0);
    $display("load aborted t0=%0d writes=%0d last_addr=%0d", t0, wr_count, last_addr);
    chk("abort_last_addr", 32'(last_addr), 32'd15);
    run_load(0, -1, 1'b0, -1, t0);
    $display("load restart t0=%0d writes=%0d done_cyc=%0d", t0, wr_count, done_cyc);
    chk_full_rate("restart", t0);

    if (CK != 0) begin
      fill_words(16'h0001, 1'b0, 16'h0210);
      run_load(0, -1, 1'b0, -1, t0);
      $display("load checksum_good t0=%0d err=%0b", t0, err);
      chk("ck_model_sum", 32'(m_sum), 32'h0210);
      chk("ck_good_err", 32'(err), 32'd0);
      chk("ck_good_done_cyc", 32'(done_cyc), 32'(t0 + 34));
      fill_words(16'h0001, 1'b0, 16'h0211);
      run_load(0, -1, 1'b0, -1, t0);
      repeat (3) @(posedge clk); #1;
      $display("load checksum_bad t0=%0d err=%0b", t0, err);
      chk("ck_bad_err_held", 32'(err), 32'd1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      $display("start after bad checksum err=%0b busy=%0b", err, busy);
      chk("ck_err_cleared", 32'(err), 32'd0);
      chk("ck_restart_busy", 32'(busy), 32'd1);
      rst_x = 1'b1;
      @(posedge clk); #1;
      rst_x = 1'b0;
    end

    repeat (2) @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
